calc_cmd_seq: RTL and testbench

- Byte-stream front end and result collector for the 64-bit integer arithmetic unit.
- Assembles a command byte and two 64-bit operands from an 8-bit input stream, then presents them to the arithmetic unit as stable registered signals.
- Waits a fixed settle latency, captures the 64-bit result, and streams it back out as 8 bytes with valid/ready handshakes.
- Sits directly upstream of the arithmetic unit and consumes its output.

---
 rtl/calc_cmd_seq_if.sv | 27 ++
 rtl/calc_cmd_seq.sv | 152 +++++++++++++++
 tb/tb_calc_cmd_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/calc_cmd_seq_if.sv
// Byte-stream, result-stream and arithmetic-unit signals of calc_cmd_seq.
// The sequencer takes the slave side. The stream source, the result sink and the arithmetic unit take the master side.
interface calc_cmd_seq_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  operation;
  logic [63:0] opa;
  logic [63:0] opb;
  logic [63:0] calc_res;
  logic        busy;
  logic        err;
  logic        dz;

  modport slave (
    input  in_data, in_valid, out_ready, calc_res,
    output in_ready, out_data, out_valid, operation, opa, opb, busy, err, dz
  );

  modport master (
    output in_data, in_valid, out_ready, calc_res,
    input  in_ready, out_data, out_valid, operation, opa, opb, busy, err, dz
  );
endinterface

// File: rtl/calc_cmd_seq.sv
// Command/operand byte assembler and result serializer for the 64-bit arithmetic unit.
// It feeds the unit registered operands, waits CALC_LAT cycles, then streams the result out as 8 bytes.
module calc_cmd_seq #(
  parameter int unsigned CALC_LAT  = 2,
  parameter bit          LSB_FIRST = 1'b1
) (
  input logic           clk,
  input logic           rst,
  calc_cmd_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, SEND} state_t;

  localparam logic [3:0] LAT_LAST = 4'(CALC_LAT - 1);

  state_t      state_q;
  logic [2:0]  op_q;
  logic [63:0] opa_q, opb_q, res_q;
  logic [2:0]  byte_cnt_q;
  logic [3:0]  lat_cnt_q;
  logic        in_ready_q, out_valid_q, busy_q, err_q, dz_q;
  logic [7:0]  out_data_q;

  logic        in_xfer, out_xfer, cmd_legal, last_byte, div_zero;
  logic [63:0] opa_d, opb_d;

  // Bit offset of stream byte idx inside a 64-bit word for the configured byte order.
  function automatic logic [5:0] lane(input logic [2:0] idx);
    return LSB_FIRST ? {idx, 3'b000} : {~idx, 3'b000};
  endfunction

  function automatic logic [63:0] put_byte(input logic [63:0] word, input logic [2:0] idx,
                                           input logic [7:0] b);
    logic [63:0] w;
    w = word;
    w[lane(idx) +: 8] = b;
    return w;
  endfunction

  function automatic logic [7:0] get_byte(input logic [63:0] word, input logic [2:0] idx);
    return word[lane(idx) +: 8];
  endfunction

  assign in_xfer   = bus.in_valid && in_ready_q;
  assign out_xfer  = out_valid_q && bus.out_ready;
  assign cmd_legal = (bus.in_data[7:3] == 5'd0) && (bus.in_data[2:0] <= 3'd4);
  assign last_byte = (byte_cnt_q == 3'd7);
  assign opa_d     = put_byte(opa_q, byte_cnt_q, bus.in_data);
  assign opb_d     = put_byte(opb_q, byte_cnt_q, bus.in_data);
  // The zero test looks at opb including the byte that arrives in this cycle.
  assign div_zero  = ((op_q == 3'd3) || (op_q == 3'd4)) && (opb_d == 64'd0);

  // NOTE: all state and registered outputs use non-blocking assignments in this one clocked block.
  // Every read then sees the value from before the edge, and the reset branch clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 3'd0;
      opa_q       <= 64'd0;
      opb_q       <= 64'd0;
      res_q       <= 64'd0;
      byte_cnt_q  <= 3'd0;
      lat_cnt_q   <= 4'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_xfer) begin
            if (cmd_legal) begin
              op_q       <= bus.in_data[2:0];
              dz_q       <= 1'b0;
              byte_cnt_q <= 3'd0;
              busy_q     <= 1'b1;
              state_q    <= LOAD_A;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD_A: begin
          if (in_xfer) begin
            opa_q      <= opa_d;
            byte_cnt_q <= byte_cnt_q + 3'd1;
            if (last_byte) state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (in_xfer) begin
            opb_q      <= opb_d;
            byte_cnt_q <= byte_cnt_q + 3'd1;
            if (last_byte) begin
              in_ready_q <= 1'b0;
              if (div_zero) begin
                // A division by zero skips the arithmetic unit and returns all ones.
                res_q       <= '1;
                dz_q        <= 1'b1;
                out_data_q  <= 8'hFF;
                out_valid_q <= 1'b1;
                state_q     <= SEND;
              end else begin
                state_q <= EXEC;
              end
            end
          end
        end
        EXEC: begin
          if (lat_cnt_q == LAT_LAST) begin
            res_q       <= bus.calc_res;
            out_data_q  <= get_byte(bus.calc_res, 3'd0);
            out_valid_q <= 1'b1;
            lat_cnt_q   <= 4'd0;
            state_q     <= SEND;
          end else begin
            lat_cnt_q <= lat_cnt_q + 4'd1;
          end
        end
        SEND: begin
          if (out_xfer) begin
            byte_cnt_q <= byte_cnt_q + 3'd1;
            if (last_byte) begin
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= IDLE;
            end else begin
              out_data_q <= get_byte(res_q, byte_cnt_q + 3'd1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.operation = op_q;
  assign bus.opa       = opa_q;
  assign bus.opb       = opb_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.dz        = dz_q;

endmodule

// File: tb/tb_calc_cmd_seq.sv
// Directed bench for calc_cmd_seq (CALC_LAT=2, little-endian) with a behavioural arithmetic-unit stub.
module tb_calc_cmd_seq;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   err_cnt = 0;
  int   err_base;
  logic [63:0] w;

  calc_cmd_seq_if bus ();

  calc_cmd_seq #(.CALC_LAT(2), .LSB_FIRST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic-unit stub: 0 add, 1 sub, 2 mul, 3 div, 4 rem.
  always_comb begin
    bus.calc_res = 64'd0;
    case (bus.operation)
      3'd0: bus.calc_res = bus.opa + bus.opb;
      3'd1: bus.calc_res = bus.opa - bus.opb;
      3'd2: bus.calc_res = bus.opa * bus.opb;
      3'd3: bus.calc_res = (bus.opb == 64'd0) ? '1 : bus.opa / bus.opb;
      3'd4: bus.calc_res = (bus.opb == 64'd0) ? '1 : bus.opa % bus.opb;
      default: bus.calc_res = 64'd0;
    endcase
  end

  always @(negedge clk) if (bus.err === 1'b1) err_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    check("in_ready_load", bus.in_ready, 1);
    @(posedge clk);
  endtask

  task automatic send_word(input logic [63:0] v, input int n);
    for (int k = 0; k < n; k++) send_byte(v[8*k +: 8]);
  endtask

  // Returns at the negedge after the last opb byte, with in_valid still high on a junk byte.
  task automatic send_frame(input logic [7:0] cmd, input logic [63:0] a, input logic [63:0] b);
    send_byte(cmd);
    send_word(a, 8);
    send_word(b, 8);
    @(negedge clk);
    bus.in_data = 8'h55;
  endtask

  task automatic recv_word(input int stall_at, input logic [7:0] stall_byte,
                           output logic [63:0] r);
    int guard;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      guard = 0;
      @(negedge clk);
      bus.out_ready = 1'b1;
      while (bus.out_valid !== 1'b1 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        check("out_valid_wait", bus.out_valid, 1);
        bus.out_ready = 1'b0;
        return;
      end
      if (k == stall_at) begin
        bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", bus.out_valid, 1);
          check("stall_data", bus.out_data, stall_byte);
          check("stall_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
      end
      r[8*k +: 8] = bus.out_data;
      @(posedge clk);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("done_valid", bus.out_valid, 0);
    check("done_busy", bus.busy, 0);
    check("done_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    rst           = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    check("rst_dz", bus.dz, 0);
    check("rst_operation", bus.operation, 0);
    check("rst_opa", bus.opa, 0);
    check("rst_opb", bus.opb, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_busy", bus.busy, 0);

    // Add 5 + 7, with junk held on in_valid during EXEC and the latency edges checked.
    err_base = err_cnt;
    send_frame(8'h00, 64'd5, 64'd7);
    check("add_exec_valid0", bus.out_valid, 0);
    check("add_exec_busy", bus.busy, 1);
    check("add_exec_in_ready", bus.in_ready, 0);
    @(negedge clk);
    check("add_exec_valid1", bus.out_valid, 0);
    @(negedge clk);
    check("add_send_valid", bus.out_valid, 1);
    check("add_first_byte", bus.out_data, 8'h0C);
    bus.in_valid = 1'b0;
    recv_word(-1, 8'h00, w);
    check("add_result", w, 64'h0C);
    check("add_dz", bus.dz, 0);
    check("add_opa", bus.opa, 64'd5);
    check("add_opb", bus.opb, 64'd7);
    check("add_operation", bus.operation, 3'd0);
    check("add_no_err", err_cnt, err_base);

    // Subtract with wrap.
    send_frame(8'h01, 64'd3, 64'd5);
    bus.in_valid = 1'b0;
    recv_word(-1, 8'h00, w);
    check("sub_result", w, 64'hFFFF_FFFF_FFFF_FFFE);

    // Divide by zero skips EXEC.
    send_frame(8'h03, 64'd100, 64'd0);
    check("dz_valid_early", bus.out_valid, 1);
    check("dz_flag", bus.dz, 1);
    check("dz_first_byte", bus.out_data, 8'hFF);
    bus.in_valid = 1'b0;
    recv_word(-1, 8'h00, w);
    check("dz_result", w, 64'hFFFF_FFFF_FFFF_FFFF);
    check("dz_flag_held", bus.dz, 1);

    // Illegal commands.
    err_base = err_cnt;
    send_byte(8'h05);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("ill05_err", bus.err, 1);
    check("ill05_busy", bus.busy, 0);
    @(negedge clk);
    check("ill05_err_low", bus.err, 0);
    send_byte(8'h80);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("ill80_err", bus.err, 1);
    check("ill80_busy", bus.busy, 0);
    check("ill_operation", bus.operation, 3'd3);
    @(negedge clk);
    check("ill80_err_low", bus.err, 0);
    check("ill_err_count", err_cnt, err_base + 2);

    // Multiply after the illegal bytes; the legal command clears dz.
    send_frame(8'h02, 64'd6, 64'd7);
    check("mul_dz_cleared", bus.dz, 0);
    bus.in_valid = 1'b0;
    recv_word(-1, 8'h00, w);
    check("mul_result", w, 64'h2A);

    // Backpressure on byte 3 of the result.
    send_frame(8'h00, 64'h0102_0304_0506_0708, 64'h1011_1213_1415_1617);
    bus.in_valid = 1'b0;
    recv_word(3, 8'h19, w);
    check("bp_result", w, 64'h1113_1517_191B_1D1F);

    // Reset partway through opb.
    send_byte(8'h04);
    send_word(64'h0000_0000_0000_00AB, 8);
    send_word(64'd9, 3);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_busy", bus.busy, 0);
    check("mrst_in_ready", bus.in_ready, 0);
    check("mrst_operation", bus.operation, 0);
    check("mrst_opa", bus.opa, 0);
    check("mrst_opb", bus.opb, 0);
    check("mrst_out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_idle_ready", bus.in_ready, 1);
    send_frame(8'h04, 64'd17, 64'd5);
    bus.in_valid = 1'b0;
    recv_word(-1, 8'h00, w);
    check("mrst_rem_result", w, 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
